// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch front end.
// Owns the fetch PC, issues in-order word requests to instruction memory,
// buffers returned words with their PCs in a small prefetch FIFO and hands
// them to decode over a valid/ready handshake. Redirects flush the FIFO and
// drop responses to requests that were already in flight.
// Optional build macro FETCH_MISALIGN_TRAP_EN adds the instr_misaligned
// pulse for redirects whose target has non-zero low address bits.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        next_sel,
  input  logic        branch_result,
  input  logic [31:0] target_addr,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_address
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        instr_misaligned
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [31:0]   fetch_pc;
  logic [CW-1:0] inflight;
  logic [CW-1:0] discard, discard_nxt;

  // Prefetch FIFO: returned word plus the PC it was fetched from.
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [CW-1:0] fifo_wr, fifo_rd, fifo_count;

  // PCs of outstanding requests, oldest at pcq_rd.
  logic [31:0]   pcq [FIFO_DEPTH];
  logic [CW-1:0] pcq_wr, pcq_rd;

  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          credit_ok;
  logic          accept;
  logic          resp_live;
  logic          push;
  logic          pop;

  assign redirect    = next_sel | branch_result;
  assign redirect_pc = {target_addr[31:2], 2'b00};
  assign fifo_count  = fifo_wr - fifo_rd;
  assign instr_valid = (fifo_count != '0);
  assign credit_ok   = ({1'b0, inflight} + {1'b0, fifo_count}) < DEPTH_C;
  assign accept      = imem_req & imem_ready;
  // A response belongs to a live request only when nothing is left to drop.
  assign resp_live   = imem_rvalid & (discard == '0);
  assign push        = resp_live & ~redirect;
  assign pop         = instr_valid & instr_ready & ~redirect;
  assign imem_addr   = fetch_pc;

  assign instruction = instr_valid ? fifo_instr[fifo_rd[AW-1:0]] : NOP_INSTR;
  assign pc_address  = instr_valid ? fifo_pc[fifo_rd[AW-1:0]]    : fetch_pc;

  // Next state, discard count and request issue.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt   = state;
    discard_nxt = discard;
    imem_req    = 1'b0;

    if (redirect) begin
      // Everything still in flight is stale, except a response landing now.
      discard_nxt = inflight - CW'(imem_rvalid);
    end else if (imem_rvalid && discard != '0) begin
      discard_nxt = discard - CW'(1);
    end

    case (state)
      BOOT:    state_nxt = RUN;
      RUN: begin
        imem_req  = credit_ok & ~redirect;
        state_nxt = (discard_nxt != '0) ? FLUSH : RUN;
      end
      FLUSH:   state_nxt = (discard_nxt != '0) ? FLUSH : RUN;
      default: state_nxt = BOOT;
    endcase
  end

  // Control state: FSM, fetch PC, outstanding and discard counters.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      state    <= BOOT;
      fetch_pc <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else begin
      state    <= state_nxt;
      discard  <= discard_nxt;
      inflight <= inflight + CW'(accept) - CW'(imem_rvalid);
      if (redirect) begin
        fetch_pc <= redirect_pc;
      end else if (accept) begin
        fetch_pc <= fetch_pc + 32'd4;
      end
    end
  end

  // FIFO and PC-queue pointers; a redirect empties both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fifo_wr <= '0;
      fifo_rd <= '0;
      pcq_wr  <= '0;
      pcq_rd  <= '0;
    end else if (redirect) begin
      fifo_wr <= '0;
      fifo_rd <= '0;
      pcq_wr  <= '0;
      pcq_rd  <= '0;
    end else begin
      if (push)      fifo_wr <= fifo_wr + CW'(1);
      if (pop)       fifo_rd <= fifo_rd + CW'(1);
      if (accept)    pcq_wr  <= pcq_wr + CW'(1);
      if (resp_live) pcq_rd  <= pcq_rd + CW'(1);
    end
  end

  // Storage writes for the FIFO and the outstanding-PC queue.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays carry no reset; the pointers alone decide which
    // entries are meaningful.
    if (push) begin
      fifo_instr[fifo_wr[AW-1:0]] <= imem_rdata;
      fifo_pc[fifo_wr[AW-1:0]]    <= pcq[pcq_rd[AW-1:0]];
    end
    if (accept) begin
      pcq[pcq_wr[AW-1:0]] <= fetch_pc;
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // One-cycle flag for a redirect whose target is not word aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_misaligned <= 1'b0;
    end else begin
      instr_misaligned <= redirect & (target_addr[1:0] != 2'b00);
    end
  end
`else
  // Low target bits are deliberately dropped in this build.
  logic unused_target_bits;
  assign unused_target_bits = ^target_addr[1:0];
`endif

endmodule
